// File: rtl/nand_reduce_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nand_reduce_pipe                                                           |
// | Pipelined per-channel NAND/AND/NOR/OR reduction tree, valid/ready stages.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module nand_reduce_pipe #(
  parameter int N_IN  = 9,
  parameter int N_CH  = 4,
  parameter int FANIN = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_CH*N_IN-1:0] in_data,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_CH-1:0]      out_data,
  output logic [1:0]           out_mode
);

  // Bits per channel remaining after k tree levels.
  function automatic int lvl_width(input int k);
    int w;
    w = N_IN;
    for (int i = 0; i < k; i++) begin
      w = (w + FANIN - 1) / FANIN;
    end
    return w;
  endfunction

  function automatic int calc_lat();
    int w;
    int l;
    w = N_IN;
    l = 0;
    for (int i = 0; i < 64; i++) begin
      if (w > 1) begin
        w = (w + FANIN - 1) / FANIN;
        l = l + 1;
      end
    end
    return l;
  endfunction

  // Offset of stage k's register inside the flattened stage-data bus.
  function automatic int data_off(input int k);
    int o;
    o = 0;
    for (int i = 0; i < k; i++) begin
      o = o + N_CH * lvl_width(i + 1);
    end
    return o;
  endfunction

  localparam int LAT     = calc_lat();
  localparam int c_tot_w = data_off(LAT);

  logic [LAT-1:0]     r_valid;
  logic [LAT-1:0]     w_adv;
  logic [LAT-1:0]     w_up_valid;
  logic               w_all_v;
  logic [c_tot_w-1:0] w_data_all;
  logic [2*LAT-1:0]   w_mode_all;

  // A stage may advance unless it and every stage downstream are full and stalled.
  always_comb begin
    w_adv   = '0;
    w_all_v = 1'b1;
    for (int i = LAT - 1; i >= 0; i--) begin
      w_all_v  = w_all_v & r_valid[i];
      w_adv[i] = out_ready | ~w_all_v;
    end
  end

  always_comb begin
    w_up_valid    = '0;
    w_up_valid[0] = in_valid;
    for (int i = 1; i < LAT; i++) begin
      w_up_valid[i] = r_valid[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < LAT; i++) begin
        if (w_adv[i]) begin
          r_valid[i] <= w_up_valid[i];
        end
      end
    end
  end

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    localparam int   c_wi   = lvl_width(k);
    localparam int   c_wo   = lvl_width(k + 1);
    localparam int   c_pw   = c_wo * FANIN;
    localparam logic c_last = (k == LAT - 1);

    logic [N_CH*c_wi-1:0] w_src;
    logic [1:0]           w_src_mode;
    logic [N_CH*c_pw-1:0] w_pad;
    logic [N_CH*c_wo-1:0] w_red;
    logic [N_CH*c_wo-1:0] r_data;
    logic [1:0]           r_mode;

    if (k == 0) begin : g_first
      assign w_src      = in_data;
      assign w_src_mode = in_mode;
    end else begin : g_next
      assign w_src      = w_data_all[data_off(k-1) +: N_CH*c_wi];
      assign w_src_mode = w_mode_all[2*(k-1) +: 2];
    end

    // Pad the tail group with the identity of the selected gate class; invert only at the root.
    always_comb begin
      w_pad = '0;
      w_red = '0;
      for (int c = 0; c < N_CH; c++) begin
        for (int p = 0; p < c_pw; p++) begin
          w_pad[c*c_pw + p] = (p < c_wi) ? w_src[c*c_wi + ((p < c_wi) ? p : 0)]
                                         : ~w_src_mode[1];
        end
        for (int g = 0; g < c_wo; g++) begin
          w_red[c*c_wo + g] = (w_src_mode[1] ? |w_pad[c*c_pw + g*FANIN +: FANIN]
                                             : &w_pad[c*c_pw + g*FANIN +: FANIN])
                              ^ (c_last & ~w_src_mode[0]);
        end
      end
    end

    // Data only loads with a valid beat so idle X on in_data never enters the pipe.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_data <= '0;
        r_mode <= 2'b00;
      end else if (w_adv[k] && w_up_valid[k]) begin
        r_data <= w_red;
        r_mode <= w_src_mode;
      end
    end

    assign w_data_all[data_off(k) +: N_CH*c_wo] = r_data;
    assign w_mode_all[2*k +: 2]                 = r_mode;
  end

  assign in_ready  = w_adv[0];
  assign out_valid = r_valid[LAT-1];
  assign out_data  = w_data_all[data_off(LAT-1) +: N_CH];
  assign out_mode  = w_mode_all[2*(LAT-1) +: 2];

endmodule
`default_nettype wire

// File: tb/tb_nand_reduce_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_nand_reduce_pipe                                                        |
// | Directed-vector bench: default 9x4/fan-in-3 instance plus 10-input pad DUT.|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_nand_reduce_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [35:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_mode;

  logic        p_valid;
  logic        p_ready;
  logic [9:0]  p_data;
  logic [1:0]  p_mode;
  logic        p_ovalid;
  logic [0:0]  p_odata;
  logic [1:0]  p_omode;

  int n_vec;
  int n_err;

  localparam logic [35:0] c_all1 = {4{9'h1FF}};

  nand_reduce_pipe u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode)
  );

  nand_reduce_pipe #(.N_IN(10), .N_CH(1), .FANIN(3)) u_pad (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (p_valid),
    .in_ready  (p_ready),
    .in_data   (p_data),
    .in_mode   (p_mode),
    .out_valid (p_ovalid),
    .out_ready (1'b1),
    .out_data  (p_odata),
    .out_mode  (p_omode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait for the next edge, then present inputs 1 ns after it and settle.
  task automatic drive(input logic v, input logic [35:0] d, input logic [1:0] m, input logic ordy);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    out_ready = ordy;
    #1;
  endtask

  // Channel c reduces to pat[c] under AND (mode 01).
  function automatic logic [35:0] mk(input logic [3:0] pat);
    logic [35:0] d;
    for (int c = 0; c < 4; c++) begin
      d[c*9 +: 9] = pat[c] ? 9'h1FF : 9'h17F;
    end
    return d;
  endfunction

  task automatic pad_vec(input string tag, input logic [9:0] d, input logic [1:0] m, input logic exp);
    @(posedge clk);
    #1;
    p_valid = 1'b1;
    p_data  = d;
    p_mode  = m;
    @(posedge clk);
    #1;
    p_valid = 1'b0;
    chk({tag, "_early0"}, 32'(p_ovalid), 32'h0);
    @(posedge clk);
    #1;
    chk({tag, "_early1"}, 32'(p_ovalid), 32'h0);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 32'(p_ovalid), 32'h1);
    chk({tag, "_data"}, 32'(p_odata), 32'(exp));
    chk({tag, "_mode"}, 32'(p_omode), 32'(m));
  endtask

  initial begin
    logic [3:0] pats [5];
    logic [3:0] exp_mode_data [4];
    int n_in;
    int n_out;
    int cyc_used;
    int ghosts;

    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 2'b00;
    out_ready = 1'b1;
    p_valid   = 1'b0;
    p_data    = '0;
    p_mode    = 2'b00;
    pats          = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    exp_mode_data = '{4'h0, 4'hF, 4'h0, 4'hF};
    #2 rst = 1'b1;

    // Reset held for three edges with a live beat presented.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 36'h5A5A5A5A5, 2'b00, 1'b1);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h1);
    end

    // Release mid-cycle; the beat presented is accepted on the next edge.
    drive(1'b1, {9'h0FF, 9'h000, 9'h1FE, 9'h1FF}, 2'b00, 1'b1);
    rst = 1'b0;
    #1;
    chk("func_in_ready", 32'(in_ready), 32'h1);
    drive(1'b0, '0, 2'b00, 1'b1);
    chk("func_lat_early", 32'(out_valid), 32'h0);
    drive(1'b0, '0, 2'b00, 1'b1);
    chk("func_valid", 32'(out_valid), 32'h1);
    chk("func_data", 32'(out_data), 32'hE);
    chk("func_mode", 32'(out_mode), 32'h0);
    drive(1'b0, '0, 2'b00, 1'b1);
    chk("func_drained", 32'(out_valid), 32'h0);

    // Four back-to-back beats with a different mode each.
    for (int k = 0; k < 6; k++) begin
      drive(k < 4, c_all1, 2'(k), 1'b1);
      if (k >= 2) begin
        chk("mode_valid", 32'(out_valid), 32'h1);
        chk("mode_data", 32'(out_data), 32'(exp_mode_data[k-2]));
        chk("mode_mode", 32'(out_mode), 32'(k-2));
      end
    end
    for (int k = 0; k < 3; k++) drive(1'b0, '0, 2'b00, 1'b1);

    // Backpressure: only two beats fit with out_ready low.
    n_in = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, mk(pats[n_in]), 2'b01, 1'b0);
      if (k >= 2) begin
        chk("bp_hold_valid", 32'(out_valid), 32'h1);
        chk("bp_hold_data", 32'(out_data), 32'(pats[0]));
      end
      if (in_ready) n_in = n_in + 1;
    end
    chk("bp_accepted", 32'(n_in), 32'h2);
    chk("bp_in_ready", 32'(in_ready), 32'h0);

    n_out    = 0;
    cyc_used = 0;
    for (int k = 0; k < 20 && n_out < 5; k++) begin
      if (n_in < 5) drive(1'b1, mk(pats[n_in]), 2'b01, 1'b1);
      else          drive(1'b0, '0, 2'b00, 1'b1);
      cyc_used = cyc_used + 1;
      if (out_valid && out_ready) begin
        chk("bp_order", 32'(out_data), 32'(pats[n_out]));
        n_out = n_out + 1;
      end
      if (in_valid && in_ready) n_in = n_in + 1;
    end
    chk("bp_out_count", 32'(n_out), 32'h5);
    chk("bp_cycles", 32'(cyc_used), 32'h5);

    // Asynchronous reset with two beats in flight.
    drive(1'b1, c_all1, 2'b01, 1'b0);
    drive(1'b1, c_all1, 2'b01, 1'b0);
    drive(1'b0, '0, 2'b00, 1'b0);
    chk("mid_pre_valid", 32'(out_valid), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("mid_valid_cleared", 32'(out_valid), 32'h0);
    chk("mid_data_cleared", 32'(out_data), 32'h0);
    #1 rst = 1'b0;
    ghosts = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, '0, 2'b00, 1'b1);
      if (out_valid) ghosts = ghosts + 1;
    end
    chk("mid_no_ghost", 32'(ghosts), 32'h0);

    // Tail-group padding on the 10-input tree.
    pad_vec("pad_and_ones", 10'h3FF, 2'b01, 1'b1);
    pad_vec("pad_or_msb", 10'h200, 2'b11, 1'b1);
    pad_vec("pad_nor_zero", 10'h000, 2'b10, 1'b1);
    pad_vec("pad_nand_ones", 10'h3FF, 2'b00, 1'b0);
    pad_vec("pad_or_zero", 10'h000, 2'b11, 1'b0);
    pad_vec("pad_and_msb0", 10'h1FF, 2'b01, 1'b0);
    pad_vec("pad_nor_msb", 10'h200, 2'b10, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
